motion_sequencer: RTL
=====================

# motion_sequencer

Command-level front end for the step generator. Accepts absolute target angles through a valid/ready queue and tracks the current shaft position. It converts each target into an unsigned relative angle plus a direction bit, then drives the generator's enable/done handshake one move at a time. It sits directly upstream of the step pulse generator: `step_enable_o` and `relative_angle_o` feed that block's enable and relative-angle inputs, and its done output returns as `step_done_i`.

## Interface
Parameters:
- `SIZE`, 64: datapath width; angles are signed Q(SIZE>>1).(SIZE>>1), two's complement.
- `DEPTH`, 4: command queue entries; power of two, ≥2.
- `GUARD`, 16: clk_i cycles for which `step_done_i` is ignored after `step_enable_o` rises.
- `TIMEOUT`, 100000000: RUN watchdog limit in clk_i cycles; used only with the macro below.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid_i` in 1: a command is present.
- `cmd_ready_o` out 1: the queue can accept a command; equals count < DEPTH.
- `cmd_angle_i` in SIZE: absolute target angle.
- `home_i` in 1: zero the position; honoured only in IDLE.
- `step_done_i` in 1: done from the step generator.
- `step_enable_o` out 1: enable to the step generator.
- `relative_angle_o` out SIZE: unsigned move magnitude.
- `dir_o` out 1: 1 = negative move.
- `position_o` out SIZE: current absolute position, signed.
- `busy_o` out 1: the FSM is not IDLE, or the queue is non-empty.
- `cmd_done_o` out 1: one-cycle pulse per completed or skipped command.
- `fault_o` out 1: sticky watchdog fault (macro builds only).

## Operation
- Queue: a FIFO with DEPTH entries.
  - A push happens on valid & ready.
  - A pop happens only on the IDLE→LOAD transition.
  - A push and a pop in the same cycle leave the count unchanged.
  - When the queue is full, a push is refused even if a pop occurs in the same cycle.
- FSM states: IDLE, LOAD, SETUP, RUN, RELEASE.
  - IDLE:
    - If `home_i` is high, set position to 0 and stay in IDLE. home wins over pop; the pop waits one cycle.
    - Otherwise, if the queue is non-empty, pop the head into `target` and go to LOAD.
  - LOAD: compute delta = target − position, modulo 2^SIZE.
    - `dir_o` = delta[SIZE−1].
    - `relative_angle_o` = |delta|. For delta = −2^(SIZE−1), clamp the magnitude to 2^(SIZE−1)−1.
    - If delta = 0: pulse `cmd_done_o` and go to IDLE. No enable is issued.
    - Otherwise go to SETUP.
  - SETUP: one cycle, so that direction and magnitude are stable before enable. Then go to RUN.
  - RUN:
    - `step_enable_o` = 1.
    - The guard counter counts GUARD cycles; `step_done_i` is ignored during this time.
    - After the guard, `step_done_i` high does all of the following: set position to target, pulse `cmd_done_o`, drop enable, go to RELEASE.
  - RELEASE: enable = 0. Wait for `step_done_i` low, then go to IDLE.
- `relative_angle_o` and `dir_o` hold their values from LOAD until the next LOAD.
- `home_i` outside IDLE is ignored; it is not latched.

## Timing
- Reset values:
  - `cmd_ready_o` 1.
  - `step_enable_o`, `relative_angle_o`, `dir_o`, `position_o`, `busy_o`, `cmd_done_o`, `fault_o` all 0.
  - Queue empty; state IDLE.
- Latency for a push accepted at edge 0 into an empty, idle block:
  - pop at edge 1 (enter LOAD);
  - outputs registered at edge 2 (enter SETUP);
  - `step_enable_o` high after edge 3.
- Latency for a zero move: `cmd_done_o` high in the cycle after edge 2.
- Completion: `step_done_i` is sampled high at edge k (after the guard). After edge k, `step_enable_o` is 0, `position_o` is updated, and `cmd_done_o` is high for exactly one cycle.
- Back-to-back commands: the minimum gap between enable pulses is RELEASE + IDLE + LOAD + SETUP = 4 cycles once `step_done_i` falls.
- Reset asserted mid-move: everything returns to the reset values immediately (asynchronous), and queued commands are discarded.
- All outputs are registered except `cmd_ready_o` and `busy_o`, which decode registered state.

## Configuration
- `MOTION_SEQUENCER_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in RUN.
  - On reaching TIMEOUT, it drops enable, leaves the position unchanged, flushes the queue, sets `fault_o`, and goes to RELEASE. No `cmd_done_o` pulse is produced.
  - While `fault_o` is set, `cmd_ready_o` is 0 and IDLE performs no pops. Only `rst_i` clears the fault.
- `MOTION_SEQUENCER_TIMEOUT_EN` undefined: no watchdog logic; `fault_o` is tied to 0.

## Test plan
- Reset, then push 90.0 (Q32.32) with step_done_i returned 50 cycles after enable: `dir_o`=0, `relative_angle_o`=90.0, enable high for 50 cycles, `position_o`=90.0, one `cmd_done_o` pulse.
- From position 90.0, push 30.0: `dir_o`=1, `relative_angle_o`=60.0, final `position_o`=30.0.
- Push 30.0 at position 30.0: no enable issued, `cmd_done_o` 3 cycles after the push, position unchanged.
- Fill the queue with 5 pushes while busy (DEPTH=4): the fifth is refused (`cmd_ready_o`=0); the four accepted commands execute in order with ≥4-cycle gaps.
- Hold step_done_i high throughout: completion occurs only after GUARD=16 cycles of enable; assert `rst_i` during RUN and check that all outputs and the queue are cleared asynchronously.
- With the macro and TIMEOUT=1000, never return done: after 1000 RUN cycles enable drops, `fault_o`=1, queue empty, `cmd_ready_o`=0 until reset.

Source files
------------

// File: rtl/motion_sequencer.sv
// Command front end for the step pulse generator: queues absolute targets, issues relative moves.
// Define MOTION_SEQUENCER_TIMEOUT_EN to add the RUN watchdog and sticky fault_o.
module motion_sequencer #(
   parameter int SIZE    = 64,
   parameter int DEPTH   = 4,
   parameter int GUARD   = 16,
   parameter int TIMEOUT = 100000000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [SIZE-1:0] cmd_angle_i,
   input  logic            home_i,
   input  logic            step_done_i,
   output logic            step_enable_o,
   output logic [SIZE-1:0] relative_angle_o,
   output logic            dir_o,
   output logic [SIZE-1:0] position_o,
   output logic            busy_o,
   output logic            cmd_done_o,
   output logic            fault_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GUARD + 2);
   localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
   localparam logic [GW-1:0] GUARD_END = GW'(GUARD);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, RUN, RELEASE} state_t;
   state_t state, next_state;

   logic [SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [SIZE-1:0] target, position, delta, neg_delta, magnitude;
   logic [GW-1:0]   guard_cnt;
   logic            push, pop, zero_move, complete, abort, timeout, fault;

   assign push        = cmd_valid_i && cmd_ready_o;
   assign cmd_ready_o = (count < FULL) && !fault;
   assign busy_o      = (state != IDLE) || (count != '0);
   assign position_o  = position;
   assign fault_o     = fault;

   // Only -2^(SIZE-1) negates to itself; clamp it to the largest positive magnitude.
   assign delta     = target - position;
   assign neg_delta = '0 - delta;
   assign magnitude = !delta[SIZE-1]   ? delta :
                      neg_delta[SIZE-1] ? {1'b0, {(SIZE-1){1'b1}}} : neg_delta;

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      zero_move  = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE:
            if (!home_i && count != '0 && !fault) begin
               pop        = 1'b1;
               next_state = LOAD;
            end
         LOAD:
            if (delta == '0) begin
               zero_move  = 1'b1;
               next_state = IDLE;
            end else begin
               next_state = SETUP;
            end
         SETUP:
            next_state = RUN;
         RUN:
            if (guard_cnt == GUARD_END && step_done_i) begin
               complete   = 1'b1;
               next_state = RELEASE;
            end else if (timeout) begin
               abort      = 1'b1;
               next_state = RELEASE;
            end
         RELEASE:
            if (!step_done_i) next_state = IDLE;
         default:
            next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= cmd_angle_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         target           <= '0;
         position         <= '0;
         relative_angle_o <= '0;
         dir_o            <= 1'b0;
         step_enable_o    <= 1'b0;
         cmd_done_o       <= 1'b0;
         guard_cnt        <= '0;
      end else begin
         if (pop) target <= mem[rd_ptr];
         if (state == IDLE && home_i) position <= '0;
         else if (complete)           position <= target;
         if (state == LOAD) begin
            relative_angle_o <= magnitude;
            dir_o            <= delta[SIZE-1];
         end
         step_enable_o <= (next_state == RUN);
         cmd_done_o    <= complete || zero_move;
         if (state != RUN)                guard_cnt <= '0;
         else if (guard_cnt != GUARD_END) guard_cnt <= guard_cnt + 1'b1;
      end
   end

`ifdef MOTION_SEQUENCER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_END = WW'(TIMEOUT - 1);
   logic [WW-1:0] wd_cnt;

   assign timeout = (state == RUN) && (wd_cnt == WD_END);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_cnt <= '0;
         fault  <= 1'b0;
      end else begin
         wd_cnt <= (state == RUN) ? wd_cnt + 1'b1 : '0;
         if (abort) fault <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign fault   = 1'b0;
`endif

endmodule
